i2c_target_regs: RTL and testbench



---
 rtl/i2c_target_regs_if.sv | 22 ++
 rtl/i2c_target_regs.sv | 198 +++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_regs_if.sv
// Pin-level and fabric-side signals of the I2C register target.
// The slave modport is the target; master is the board/fabric side that drives the pins.
interface i2c_target_regs_if;
    logic       SCL_IN;
    logic       SDA_IN;
    logic       SDA_OE;
    logic [7:0] STATUS_IN;
    logic       REG_WR_PULSE;
    logic [2:0] REG_WR_IDX;
    logic [7:0] REG_WR_DATA;
    logic       BUSY;

    modport master (
        output SCL_IN, SDA_IN, STATUS_IN,
        input  SDA_OE, REG_WR_PULSE, REG_WR_IDX, REG_WR_DATA, BUSY
    );

    modport slave (
        input  SCL_IN, SDA_IN, STATUS_IN,
        output SDA_OE, REG_WR_PULSE, REG_WR_IDX, REG_WR_DATA, BUSY
    );
endinterface

// File: rtl/i2c_target_regs.sv
// I2C target with an 8-entry byte register bank: pointer write, auto-increment
// burst write/read, register 7 reads live STATUS_IN and ignores writes.
module i2c_target_regs #(
    parameter logic [6:0] TARGET_ADDR = 7'h42
) (
    input  logic               FAB_CLK,
    input  logic               FAB_RESET,
    i2c_target_regs_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
    } state_t;

    state_t state_q, state_d;

    // [0],[1] synchronizer, [2] history; reset to the idle-high bus level
    logic [2:0] scl_sr, sda_sr;
    logic       rise_q, fall_q, start_q, stop_q;

    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic             rw_q, first_q, phase_q;
    logic [2:0]       ptr_q;
    logic [7:0][7:0]  regs_q;
    logic             oe_q, busy_q, pend_q, pulse_q;
    logic [2:0]       wr_idx_q;
    logic [7:0]       wr_data_q;

    logic       sda_h;
    logic [7:0] wbyte, rd_cur, rd_nxt;
    logic [2:0] ptr_inc;
    logic       addr_match;

    assign sda_h      = sda_sr[2];
    assign wbyte      = {shift[6:0], sda_h};
    assign ptr_inc    = ptr_q + 3'd1;
    assign addr_match = (shift[6:0] == TARGET_ADDR);
    assign rd_cur     = (ptr_q   == 3'd7) ? bus.STATUS_IN : regs_q[ptr_q];
    assign rd_nxt     = (ptr_inc == 3'd7) ? bus.STATUS_IN : regs_q[ptr_inc];

    // Events are registered so they are acted on one cycle after detection
    always_ff @(posedge FAB_CLK or posedge FAB_RESET) begin
        if (FAB_RESET) begin
            scl_sr  <= 3'b111;
            sda_sr  <= 3'b111;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            scl_sr  <= {scl_sr[1:0], bus.SCL_IN};
            sda_sr  <= {sda_sr[1:0], bus.SDA_IN};
            rise_q  <=  scl_sr[1] & ~scl_sr[2];
            fall_q  <= ~scl_sr[1] &  scl_sr[2];
            start_q <=  scl_sr[1] &  scl_sr[2] &  sda_sr[2] & ~sda_sr[1];
            stop_q  <=  scl_sr[1] &  scl_sr[2] & ~sda_sr[2] &  sda_sr[1];
        end
    end

    always_ff @(posedge FAB_CLK or posedge FAB_RESET) begin
        if (FAB_RESET) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start_q)      state_d = ADDR;
        else if (stop_q)  state_d = IDLE;
        else begin
            case (state_q)
                ADDR:     if (rise_q && bit_cnt == 3'd7)
                              state_d = addr_match ? ADDR_ACK : WAIT_STOP;
                ADDR_ACK: if (fall_q && phase_q) state_d = rw_q ? RD_BYTE : WR_BYTE;
                WR_BYTE:  if (rise_q && bit_cnt == 3'd7) state_d = WR_ACK;
                WR_ACK:   if (fall_q && phase_q) state_d = WR_BYTE;
                RD_BYTE:  if (fall_q && phase_q && bit_cnt == 3'd7) state_d = RD_ACK;
                RD_ACK:   if (rise_q) state_d = sda_h ? WAIT_STOP : RD_BYTE;
                default:  state_d = state_q;
            endcase
        end
    end

    // phase_q: in ACK states, "ACK is being driven"; in RD_BYTE, "MSB already driven"
    always_ff @(posedge FAB_CLK or posedge FAB_RESET) begin
        if (FAB_RESET) begin
            bit_cnt   <= '0;
            shift     <= '0;
            rw_q      <= 1'b0;
            first_q   <= 1'b0;
            phase_q   <= 1'b0;
            ptr_q     <= '0;
            regs_q    <= '0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            pend_q    <= 1'b0;
            pulse_q   <= 1'b0;
            wr_idx_q  <= '0;
            wr_data_q <= '0;
        end else begin
            pend_q  <= 1'b0;
            pulse_q <= pend_q;
            if (start_q) begin
                bit_cnt <= '0;
                oe_q    <= 1'b0;
                phase_q <= 1'b0;
            end else if (stop_q) begin
                oe_q    <= 1'b0;
                busy_q  <= 1'b0;
                phase_q <= 1'b0;
            end else begin
                case (state_q)
                    ADDR: if (rise_q) begin
                        shift   <= wbyte;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rw_q    <= sda_h;
                            phase_q <= 1'b0;
                            if (!addr_match) busy_q <= 1'b0;
                        end
                    end
                    ADDR_ACK: if (fall_q) begin
                        if (!phase_q) begin
                            oe_q    <= 1'b1;
                            phase_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end else begin
                            bit_cnt <= '0;
                            if (rw_q) begin
                                shift   <= rd_cur;
                                oe_q    <= ~rd_cur[7];
                            end else begin
                                oe_q    <= 1'b0;
                                phase_q <= 1'b0;
                                first_q <= 1'b1;
                            end
                        end
                    end
                    WR_BYTE: if (rise_q) begin
                        shift   <= wbyte;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            phase_q <= 1'b0;
                            if (first_q) begin
                                ptr_q   <= wbyte[2:0];
                                first_q <= 1'b0;
                            end else begin
                                if (ptr_q != 3'd7) begin
                                    regs_q[ptr_q] <= wbyte;
                                    wr_idx_q      <= ptr_q;
                                    wr_data_q     <= wbyte;
                                    pend_q        <= 1'b1;
                                end
                                ptr_q <= ptr_inc;
                            end
                        end
                    end
                    WR_ACK: if (fall_q) begin
                        oe_q    <= ~phase_q;
                        phase_q <= ~phase_q;
                        bit_cnt <= '0;
                    end
                    RD_BYTE: if (fall_q) begin
                        if (!phase_q) begin
                            oe_q    <= ~shift[7];
                            phase_q <= 1'b1;
                            bit_cnt <= '0;
                        end else if (bit_cnt == 3'd7) begin
                            oe_q    <= 1'b0;
                            phase_q <= 1'b0;
                        end else begin
                            shift   <= {shift[6:0], 1'b0};
                            oe_q    <= ~shift[6];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    RD_ACK: if (rise_q) begin
                        if (!sda_h) begin
                            ptr_q   <= ptr_inc;
                            shift   <= rd_nxt;
                            phase_q <= 1'b0;
                        end else begin
                            busy_q  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        bus.SDA_OE       = oe_q;
        bus.BUSY         = busy_q;
        bus.REG_WR_PULSE = pulse_q;
        bus.REG_WR_IDX   = wr_idx_q;
        bus.REG_WR_DATA  = wr_data_q;
    end
endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench: a bit-banged I2C host exercises writes, reads, wrap, mismatch,
// abort and reset; register contents are read back through the bus from a vector table.
module tb_i2c_target_regs;
    localparam int Q = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic host_scl = 1'b1;
    logic host_sda = 1'b1;
    logic [7:0] status = 8'h00;

    int checks = 0;
    int errors = 0;

    i2c_target_regs_if bus ();
    assign bus.SCL_IN    = host_scl;
    assign bus.SDA_IN    = host_sda & ~bus.SDA_OE;
    assign bus.STATUS_IN = status;

    i2c_target_regs #(.TARGET_ADDR(7'h42)) dut (
        .FAB_CLK   (clk),
        .FAB_RESET (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int pcnt = 0, oe_cnt = 0, busy_cnt = 0;
    logic [2:0] pidx [16];
    logic [7:0] pdat [16];
    always @(posedge clk) begin
        if (bus.REG_WR_PULSE) begin
            if (pcnt < 16) begin
                pidx[pcnt] <= bus.REG_WR_IDX;
                pdat[pcnt] <= bus.REG_WR_DATA;
            end
            pcnt <= pcnt + 1;
        end
        if (bus.SDA_OE) oe_cnt   <= oe_cnt + 1;
        if (bus.BUSY)   busy_cnt <= busy_cnt + 1;
    end

    typedef struct {
        logic [2:0] ptr;
        logic [7:0] status;
        logic [7:0] exp;
    } rd_vec_t;
    rd_vec_t vec [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic qw();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        host_sda = 1'b1; qw();
        host_scl = 1'b1; qw();
        host_sda = 1'b0; qw();
        host_scl = 1'b0; qw();
    endtask

    task automatic i2c_stop();
        host_sda = 1'b0; qw();
        host_scl = 1'b1; qw();
        host_sda = 1'b1; qw();
    endtask

    task automatic wbit(input logic b);
        host_sda = b;    qw();
        host_scl = 1'b1; qw();
        host_scl = 1'b0; qw();
    endtask

    task automatic rbit(output logic b);
        host_sda = 1'b1; qw();
        host_scl = 1'b1; qw();
        b = bus.SDA_IN;
        host_scl = 1'b0; qw();
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(ack);
    endtask

    task automatic rbyte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            d[i] = b;
        end
        wbit(nack);
    endtask

    task automatic read_reg(input logic [2:0] p, output logic [7:0] d);
        logic a;
        i2c_start();
        wbyte(8'h84, a);
        wbyte({5'b0, p}, a);
        i2c_start();
        wbyte(8'h85, a);
        rbyte(d, 1'b1);
        i2c_stop();
    endtask

    initial begin
        logic a;
        logic [7:0] d;
        int p0, o0, b0;

        vec[0] = '{3'd0, 8'h00, 8'h33};
        vec[1] = '{3'd1, 8'h00, 8'h77};
        vec[2] = '{3'd2, 8'h00, 8'hA5};
        vec[3] = '{3'd3, 8'h00, 8'h5A};
        vec[4] = '{3'd4, 8'h00, 8'h00};
        vec[5] = '{3'd5, 8'h00, 8'h00};
        vec[6] = '{3'd6, 8'h00, 8'h11};
        vec[7] = '{3'd7, 8'h96, 8'h96};
        for (int i = 0; i < 7; i++) vec[8+i] = '{3'(i), 8'h00, 8'h00};
        vec[15] = '{3'd7, 8'h3C, 8'h3C};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst SDA_OE", bus.SDA_OE, 0);
        chk("rst BUSY", bus.BUSY, 0);
        rst = 1'b0;
        qw();
        chk("rst PULSE", bus.REG_WR_PULSE, 0);
        chk("rst IDX", bus.REG_WR_IDX, 0);
        chk("rst DATA", bus.REG_WR_DATA, 0);

        // write burst
        p0 = pcnt;
        i2c_start();
        wbyte(8'h84, a); chk("wb addr ack", a, 0);
        chk("wb busy", bus.BUSY, 1);
        wbyte(8'h02, a); chk("wb ptr ack", a, 0);
        wbyte(8'hA5, a); chk("wb d0 ack", a, 0);
        wbyte(8'h5A, a); chk("wb d1 ack", a, 0);
        i2c_stop();
        chk("wb busy after stop", bus.BUSY, 0);
        chk("wb pulses", pcnt - p0, 2);
        chk("wb pulse0", {pidx[p0], pdat[p0]}, {3'd2, 8'hA5});
        chk("wb pulse1", {pidx[p0+1], pdat[p0+1]}, {3'd3, 8'h5A});
        chk("wb held idx/data", {bus.REG_WR_IDX, bus.REG_WR_DATA}, {3'd3, 8'h5A});

        // pointer write, repeated START, read with ACK then NACK
        i2c_start();
        wbyte(8'h84, a);
        wbyte(8'h02, a);
        i2c_start();
        wbyte(8'h85, a); chk("rd addr ack", a, 0);
        rbyte(d, 1'b0);  chk("rd byte0", d, 8'hA5);
        chk("rd busy mid", bus.BUSY, 1);
        rbyte(d, 1'b1);  chk("rd byte1", d, 8'h5A);
        chk("rd busy after nack", bus.BUSY, 0);
        chk("rd sda released", bus.SDA_OE, 0);
        i2c_stop();

        // wrap through read-only register 7
        p0 = pcnt;
        i2c_start();
        wbyte(8'h84, a);
        wbyte(8'h06, a);
        wbyte(8'h11, a); chk("wrap d0 ack", a, 0);
        wbyte(8'h22, a); chk("wrap r7 ack", a, 0);
        wbyte(8'h33, a); chk("wrap d2 ack", a, 0);
        i2c_stop();
        chk("wrap pulses", pcnt - p0, 2);
        chk("wrap pulse0", {pidx[p0], pdat[p0]}, {3'd6, 8'h11});
        chk("wrap pulse1", {pidx[p0+1], pdat[p0+1]}, {3'd0, 8'h33});
        status = 8'hC3;
        i2c_start();
        wbyte(8'h84, a);
        wbyte(8'h07, a);
        i2c_start();
        wbyte(8'h85, a);
        rbyte(d, 1'b0); chk("wrap rd status", d, 8'hC3);
        rbyte(d, 1'b1); chk("wrap rd reg0", d, 8'h33);
        i2c_stop();

        // address mismatch
        p0 = pcnt; o0 = oe_cnt; b0 = busy_cnt;
        i2c_start();
        wbyte(8'h86, a); chk("mm addr nack", a, 1);
        wbyte(8'h00, a);
        wbyte(8'hFF, a);
        i2c_stop();
        chk("mm no oe", oe_cnt - o0, 0);
        chk("mm no pulse", pcnt - p0, 0);
        chk("mm no busy", busy_cnt - b0, 0);

        // aborted write after 4 data bits, then a normal write
        p0 = pcnt;
        i2c_start();
        wbyte(8'h84, a);
        wbyte(8'h01, a);
        wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b0);
        i2c_stop();
        chk("abort no pulse", pcnt - p0, 0);
        chk("abort sda released", bus.SDA_OE, 0);
        chk("abort busy", bus.BUSY, 0);
        i2c_start();
        wbyte(8'h84, a);
        wbyte(8'h01, a);
        wbyte(8'h77, a); chk("post-abort ack", a, 0);
        i2c_stop();
        chk("post-abort pulse", {pidx[p0], pdat[p0]}, {3'd1, 8'h77});

        for (int i = 0; i < 8; i++) begin
            status = vec[i].status;
            read_reg(vec[i].ptr, d);
            chk($sformatf("readback reg%0d", vec[i].ptr), d, vec[i].exp);
        end

        // reset asserted while the address ACK is being driven
        i2c_start();
        for (int i = 7; i >= 0; i--) wbit(8'h84 >> i);
        chk("mid-ack oe", bus.SDA_OE, 1);
        #3 rst = 1'b1;
        #1;
        chk("reset async oe", bus.SDA_OE, 0);
        chk("reset busy", bus.BUSY, 0);
        chk("reset idx/data", {bus.REG_WR_PULSE, bus.REG_WR_IDX, bus.REG_WR_DATA}, 0);
        qw();
        rst = 1'b0;
        qw();
        i2c_stop();

        for (int i = 8; i < 16; i++) begin
            status = vec[i].status;
            read_reg(vec[i].ptr, d);
            chk($sformatf("post-reset reg%0d", vec[i].ptr), d, vec[i].exp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
